// File: rtl/mash_ctrl.sv
// MASH accumulator sequencing controller: flush, seed load, settle blanking, phase-step pulses.
// Optional macro MASH_CTRL_CFG_RESTART_EN: order/width changes in SETTLE or RUN force a restart.
module mash_ctrl #(
    parameter int FLUSH_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_seed,
    input  logic [1:0]  i_sel_order,
    input  logic [3:0]  i_mash_bit,
    input  logic        i_mashreseten,
    input  logic        i_phaseadjusten,
    input  logic        i_sel_frac,
    output logic        o_acc_clr,
    output logic        o_seed_load,
    output logic [11:0] o_seed,
    output logic [1:0]  o_sel_order,
    output logic [3:0]  o_mash_bit,
    output logic        o_sel_frac,
    output logic        o_phase_step,
    output logic        o_out_valid,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_FLUSH  = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_pend;
    logic             w_pend_next;
    logic             w_step_next;
    logic             r_pa_d;
    logic             w_pa_rise;
    logic             w_cfg_change;

    logic             r_acc_clr;
    logic             r_seed_load;
    logic [11:0]      r_seed;
    logic [1:0]       r_sel_order;
    logic [3:0]       r_mash_bit;
    logic             r_sel_frac;
    logic             r_phase_step;
    logic             r_out_valid;
    logic             r_busy;

    assign w_pa_rise = i_phaseadjusten & ~r_pa_d;

`ifdef MASH_CTRL_CFG_RESTART_EN
    assign w_cfg_change = ((r_state == ST_SETTLE) || (r_state == ST_RUN)) &&
                          ((i_sel_order != r_sel_order) || (i_mash_bit != r_mash_bit));
`else
    assign w_cfg_change = 1'b0;
`endif

    // Restart requests dominate everything, including a coincident phase edge.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pend_next  = r_pend;
        w_step_next  = 1'b0;
        if (i_mashreseten || w_cfg_change) begin
            w_state_next = ST_FLUSH;
            w_cnt_next   = '0;
            w_pend_next  = 1'b0;
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    if (w_pa_rise) w_pend_next = 1'b1;
                    if (r_cnt == FLUSH_LAST) begin
                        w_state_next = ST_LOAD;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_pa_rise) w_pend_next = 1'b1;
                    w_state_next = ST_SETTLE;
                    w_cnt_next   = '0;
                end
                ST_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        // An edge on the final settle cycle merges into the first-RUN pulse.
                        w_state_next = ST_RUN;
                        w_cnt_next   = '0;
                        w_step_next  = r_pend | w_pa_rise;
                        w_pend_next  = 1'b0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                        if (w_pa_rise) w_pend_next = 1'b1;
                    end
                end
                ST_RUN: begin
                    w_step_next = w_pa_rise;
                end
                default: begin
                    w_state_next = ST_FLUSH;
                    w_cnt_next   = '0;
                    w_pend_next  = 1'b0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_FLUSH;
            r_cnt        <= '0;
            r_pend       <= 1'b0;
            r_pa_d       <= 1'b0;
            r_acc_clr    <= 1'b1;
            r_busy       <= 1'b1;
            r_seed_load  <= 1'b0;
            r_phase_step <= 1'b0;
            r_out_valid  <= 1'b0;
            r_seed       <= '0;
            r_sel_order  <= '0;
            r_mash_bit   <= '0;
            r_sel_frac   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_pend       <= w_pend_next;
            r_pa_d       <= i_phaseadjusten;
            r_acc_clr    <= (w_state_next == ST_FLUSH);
            r_seed_load  <= (w_state_next == ST_LOAD);
            r_out_valid  <= (w_state_next == ST_RUN);
            r_busy       <= (w_state_next != ST_RUN);
            r_phase_step <= w_step_next;
            if (w_state_next == ST_LOAD) begin
                r_seed      <= i_seed;
                r_sel_order <= i_sel_order;
                r_mash_bit  <= i_mash_bit;
                r_sel_frac  <= i_sel_frac;
            end
        end
    end

    assign o_acc_clr    = r_acc_clr;
    assign o_seed_load  = r_seed_load;
    assign o_seed       = r_seed;
    assign o_sel_order  = r_sel_order;
    assign o_mash_bit   = r_mash_bit;
    assign o_sel_frac   = r_sel_frac;
    assign o_phase_step = r_phase_step;
    assign o_out_valid  = r_out_valid;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_mash_ctrl.sv
// Scoreboard bench for mash_ctrl: expected load/step/valid-rise cycles are queued at
// stimulus time and popped by a negedge monitor when the DUT produces the event.
module tb_mash_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] i_seed = 12'hA5C;
    logic [1:0]  i_sel_order = 2'd1;
    logic [3:0]  i_mash_bit = 4'd9;
    logic        i_mashreseten = 1'b0;
    logic        i_phaseadjusten = 1'b0;
    logic        i_sel_frac = 1'b1;
    logic        o_acc_clr, o_seed_load, o_sel_frac, o_phase_step, o_out_valid, o_busy;
    logic [11:0] o_seed;
    logic [1:0]  o_sel_order;
    logic [3:0]  o_mash_bit;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    logic valid_q = 1'b0;

    int          exp_load_cyc[$];
    logic [11:0] exp_load_seed[$];
    int          exp_step_cyc[$];
    int          exp_valid_cyc[$];

    mash_ctrl #(.FLUSH_CYCLES(4), .SETTLE_CYCLES(8), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_seed(i_seed), .i_sel_order(i_sel_order),
        .i_mash_bit(i_mash_bit), .i_mashreseten(i_mashreseten),
        .i_phaseadjusten(i_phaseadjusten), .i_sel_frac(i_sel_frac),
        .o_acc_clr(o_acc_clr), .o_seed_load(o_seed_load), .o_seed(o_seed),
        .o_sel_order(o_sel_order), .o_mash_bit(o_mash_bit), .o_sel_frac(o_sel_frac),
        .o_phase_step(o_phase_step), .o_out_valid(o_out_valid), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every load / step / valid-rise must match the head of its queue.
    always @(negedge clk) begin
        if (o_seed_load) begin
            if (exp_load_cyc.size() == 0) check("load_unexpected", 32'd1, 32'd0);
            else begin
                check("load_cycle", cyc, exp_load_cyc.pop_front());
                check("load_seed", 32'(o_seed), 32'(exp_load_seed.pop_front()));
            end
        end
        if (o_phase_step) begin
            if (exp_step_cyc.size() == 0) check("step_unexpected", 32'd1, 32'd0);
            else check("step_cycle", cyc, exp_step_cyc.pop_front());
        end
        if (o_out_valid && !valid_q) begin
            if (exp_valid_cyc.size() == 0) check("valid_unexpected", 32'd1, 32'd0);
            else check("valid_cycle", cyc, exp_valid_cyc.pop_front());
        end
        valid_q <= o_out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_load_q"}, exp_load_cyc.size(), 32'd0);
        check({tag, "_step_q"}, exp_step_cyc.size(), 32'd0);
        check({tag, "_valid_q"}, exp_valid_cyc.size(), 32'd0);
        exp_load_cyc.delete();
        exp_load_seed.delete();
        exp_step_cyc.delete();
        exp_valid_cyc.delete();
    endtask

    // One-cycle modulator reset: LOAD 5 cycles later, valid 9 after that.
    task automatic pulse_reset(output int c);
        c = cyc;
        i_mashreseten = 1'b1;
        exp_load_cyc.push_back(c + 5);
        exp_load_seed.push_back(i_seed);
        exp_valid_cyc.push_back(c + 14);
        tick();
        i_mashreseten = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;

        // Reset values while reset is held.
        tick(); tick();
        check("rst_acc_clr", 32'(o_acc_clr), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd1);
        check("rst_valid", 32'(o_out_valid), 32'd0);
        check("rst_seed_load", 32'(o_seed_load), 32'd0);
        check("rst_step", 32'(o_phase_step), 32'd0);
        check("rst_seed", 32'(o_seed), 32'd0);

        // Release: 4 flush cycles, load of A5C, valid 9 cycles after load.
        c = cyc;
        rst = 1'b0;
        exp_load_cyc.push_back(c + 4);
        exp_load_seed.push_back(12'hA5C);
        exp_valid_cyc.push_back(c + 13);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (o_acc_clr) n++;
        end
        check("init_acc_clr_cycles", n, 32'd4);
        wait_until(c + 20);
        check_drained("init");
        check("init_valid", 32'(o_out_valid), 32'd1);
        check("init_busy", 32'(o_busy), 32'd0);
        check("init_seed", 32'(o_seed), 32'hA5C);
        check("init_order", 32'(o_sel_order), 32'd1);
        check("init_mash_bit", 32'(o_mash_bit), 32'd9);
        check("init_frac", 32'(o_sel_frac), 32'd1);

        // Modulator reset held 10 cycles in RUN.
        c = cyc;
        i_mashreseten = 1'b1;
        i_seed = 12'h3C1;
        exp_load_cyc.push_back(c + 14);
        exp_load_seed.push_back(12'h3C1);
        exp_valid_cyc.push_back(c + 23);
        tick();
        check("mrst_valid_drop", 32'(o_out_valid), 32'd0);
        check("mrst_busy", 32'(o_busy), 32'd1);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            if (o_acc_clr) n++;
            if (k == 10) i_mashreseten = 1'b0;
            tick();
        end
        check("mrst_acc_clr_cycles", n, 32'd13);
        wait_until(c + 30);
        check_drained("mrst");

        // Phase edge in RUN, held high, then two edges at minimum spacing.
        c = cyc;
        i_phaseadjusten = 1'b1;
        exp_step_cyc.push_back(c + 1);
        wait_until(c + 5);
        i_phaseadjusten = 1'b0;
        wait_until(c + 6);
        i_phaseadjusten = 1'b1;
        exp_step_cyc.push_back(c + 7);
        wait_until(c + 7);
        i_phaseadjusten = 1'b0;
        wait_until(c + 8);
        i_phaseadjusten = 1'b1;
        exp_step_cyc.push_back(c + 9);
        wait_until(c + 9);
        i_phaseadjusten = 1'b0;
        wait_until(c + 14);
        check_drained("run_step");

        // Three edges during SETTLE collapse to one pulse in the first RUN cycle.
        pulse_reset(c);
        exp_step_cyc.push_back(c + 14);
        for (int k = 6; k <= 11; k++) begin
            wait_until(c + k);
            i_phaseadjusten = (k % 2 == 0);
        end
        wait_until(c + 20);
        check_drained("settle_step");

        // Edge on the last SETTLE cycle.
        pulse_reset(c);
        exp_step_cyc.push_back(c + 14);
        wait_until(c + 13);
        i_phaseadjusten = 1'b1;
        wait_until(c + 18);
        i_phaseadjusten = 1'b0;
        wait_until(c + 22);
        check_drained("last_settle_step");

        // Edge coincident with modulator reset: no pulse ever.
        c = cyc;
        i_phaseadjusten = 1'b1;
        pulse_reset(c);
        wait_until(c + 18);
        i_phaseadjusten = 1'b0;
        wait_until(c + 24);
        check_drained("edge_with_reset");

        // Seed / fractional changes in RUN never restart or alter outputs.
        i_seed = 12'h777;
        i_sel_frac = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (o_out_valid) n++;
        end
        check("seedchg_valid_cycles", n, 32'd10);
        check("seedchg_seed_held", 32'(o_seed), 32'h3C1);
        check("seedchg_frac_held", 32'(o_sel_frac), 32'd1);

        // Order change 1 -> 3 in RUN.
        c = cyc;
        i_sel_order = 2'd3;
`ifdef MASH_CTRL_CFG_RESTART_EN
        exp_load_cyc.push_back(c + 5);
        exp_load_seed.push_back(12'h777);
        exp_valid_cyc.push_back(c + 14);
        tick();
        check("cfg_restart_valid_drop", 32'(o_out_valid), 32'd0);
        wait_until(c + 20);
        check_drained("cfg_restart");
        check("cfg_order_new", 32'(o_sel_order), 32'd3);
        check("cfg_valid", 32'(o_out_valid), 32'd1);
`else
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (o_out_valid) n++;
        end
        check("cfg_ignored_valid_cycles", n, 32'd20);
        check_drained("cfg_ignored");
        check("cfg_order_held", 32'(o_sel_order), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
